// File: rtl/fpga_pkg.sv
// Shared types for the fpga_dffer_pipe register pipeline.
package fpga_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    SHIFT = 2'b01,
    LOAD  = 2'b10,
    CLEAR = 2'b11
  } dffer_mode_e;

endpackage : fpga_pkg

// File: rtl/fpga_dffer_stage.sv
// One pipeline stage: WIDTH data bits plus valid, with enable and mode-driven next-value select.
// Optional stored parity bit when FPGA_DFFER_PIPE_PARITY_EN is defined.
module fpga_dffer_stage
  import fpga_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] shift_data_i,
  input  logic             shift_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
`ifdef FPGA_DFFER_PIPE_PARITY_EN
  input  logic             shift_par_i,
  output logic             par_o,
`endif
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (en_i) begin
      case (mode_i)
        SHIFT: begin
          data_d  = shift_data_i;
          valid_d = shift_valid_i;
        end
        LOAD: begin
          data_d  = load_data_i;
          valid_d = 1'b1;
        end
        CLEAR: begin
          data_d  = RESET_VAL;
          valid_d = 1'b0;
        end
        default: begin
          data_d  = data_q;
          valid_d = valid_q;
        end
      endcase
    end else begin
      data_d  = data_q;
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

`ifdef FPGA_DFFER_PIPE_PARITY_EN
  // Even parity: the stored bit makes data plus parity carry an even number of ones.
  function automatic logic even_par_f(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic par_d, par_q;

  always_comb begin
    par_d = par_q;
    if (en_i) begin
      case (mode_i)
        SHIFT:   par_d = shift_par_i;
        LOAD:    par_d = even_par_f(load_data_i);
        CLEAR:   par_d = even_par_f(RESET_VAL);
        default: par_d = par_q;
      endcase
    end else begin
      par_d = par_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      par_q <= even_par_f(RESET_VAL);
    end else begin
      par_q <= par_d;
    end
  end

  assign par_o = par_q;
`endif

endmodule : fpga_dffer_stage

// File: rtl/fpga_dffer_pipe.sv
// DEPTH-stage enabled shift/load/clear register pipeline with per-stage valid and occupancy count.
// Define FPGA_DFFER_PIPE_PARITY_EN to add the per-stage even-parity output par_o.
module fpga_dffer_pipe
  import fpga_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       E_i,
  input  logic [1:0]                 mode_i,
  input  logic [WIDTH-1:0]           D_i,
  input  logic [DEPTH*WIDTH-1:0]     load_i,
  output logic [WIDTH-1:0]           Q_o,
  output logic [DEPTH*WIDTH-1:0]     taps_o,
  output logic [DEPTH-1:0]           valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
`ifdef FPGA_DFFER_PIPE_PARITY_EN
  output logic [DEPTH-1:0]           par_o,
`endif
  output logic                       empty_o
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH*WIDTH-1:0] taps_s;
  logic [DEPTH*WIDTH-1:0] shift_taps_s;
  logic [DEPTH-1:0]       valid_s;
  logic [DEPTH-1:0]       shift_valid_s;
  logic [CW-1:0]          count_d, count_q;

  // Stage k shifts in from stage k-1; stage 0 takes D_i and always becomes valid.
  assign shift_taps_s  = {taps_s[(DEPTH-1)*WIDTH-1:0], D_i};
  assign shift_valid_s = {valid_s[DEPTH-2:0], 1'b1};

`ifdef FPGA_DFFER_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_s;
  logic [DEPTH-1:0] shift_par_s;
  assign shift_par_s = {par_s[DEPTH-2:0], ^D_i};
  assign par_o       = par_s;
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
`ifdef FPGA_DFFER_PIPE_PARITY_EN
    fpga_dffer_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .en_i          (E_i),
      .mode_i        (mode_i),
      .shift_data_i  (shift_taps_s[k*WIDTH +: WIDTH]),
      .shift_valid_i (shift_valid_s[k]),
      .load_data_i   (load_i[k*WIDTH +: WIDTH]),
      .shift_par_i   (shift_par_s[k]),
      .par_o         (par_s[k]),
      .data_o        (taps_s[k*WIDTH +: WIDTH]),
      .valid_o       (valid_s[k])
    );
`else
    fpga_dffer_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .en_i          (E_i),
      .mode_i        (mode_i),
      .shift_data_i  (shift_taps_s[k*WIDTH +: WIDTH]),
      .shift_valid_i (shift_valid_s[k]),
      .load_data_i   (load_i[k*WIDTH +: WIDTH]),
      .data_o        (taps_s[k*WIDTH +: WIDTH]),
      .valid_o       (valid_s[k])
    );
`endif
  end

  // Occupancy tracked incrementally; a SHIFT grows it only while the last stage is still empty.
  always_comb begin
    count_d = count_q;
    if (E_i) begin
      case (mode_i)
        SHIFT: begin
          if (!valid_s[DEPTH-1]) begin
            count_d = count_q + CW'(1);
          end else begin
            count_d = count_q;
          end
        end
        LOAD:    count_d = CW'(DEPTH);
        CLEAR:   count_d = '0;
        default: count_d = count_q;
      endcase
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign taps_o  = taps_s;
  assign Q_o     = taps_s[(DEPTH-1)*WIDTH +: WIDTH];
  assign valid_o = valid_s;
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule : fpga_dffer_pipe

// File: tb/tb_fpga_dffer_pipe.sv
// Self-checking bench for fpga_dffer_pipe (WIDTH=8, DEPTH=4): directed vector table plus random run vs. a queue-style model.
module tb_fpga_dffer_pipe;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_i;
  logic           E_i;
  logic [1:0]     mode_i;
  logic [W-1:0]   D_i;
  logic [N*W-1:0] load_i;
  logic [W-1:0]   Q_o;
  logic [N*W-1:0] taps_o;
  logic [N-1:0]   valid_o;
  logic [2:0]     count_o;
  logic           full_o;
  logic           empty_o;
`ifdef FPGA_DFFER_PIPE_PARITY_EN
  logic [N-1:0]   par_o;
`endif

  fpga_dffer_pipe #(.WIDTH(W), .DEPTH(N), .RESET_VAL(8'h00)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .E_i     (E_i),
    .mode_i  (mode_i),
    .D_i     (D_i),
    .load_i  (load_i),
    .Q_o     (Q_o),
    .taps_o  (taps_o),
    .valid_o (valid_o),
    .count_o (count_o),
    .full_o  (full_o),
`ifdef FPGA_DFFER_PIPE_PARITY_EN
    .par_o   (par_o),
`endif
    .empty_o (empty_o)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic           rst;
    logic           en;
    logic [1:0]     mode;
    logic [W-1:0]   d;
    logic [N*W-1:0] load;
    logic [N*W-1:0] exp_taps;
    logic [N-1:0]   exp_valid;
    int             exp_count;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [N*W-1:0] et, input logic [N-1:0] ev, input int ec);
    logic [N*W-1:0] t;
    t = et;
    check({tag, ".taps"},  taps_o,  et);
    check({tag, ".Q"},     {24'h0, Q_o}, {24'h0, t[N*W-1 -: W]});
    check({tag, ".valid"}, {28'h0, valid_o}, {28'h0, ev});
    check({tag, ".count"}, {29'h0, count_o}, ec);
    check({tag, ".full"},  {31'h0, full_o},  {31'h0, (ec == N)});
    check({tag, ".empty"}, {31'h0, empty_o}, {31'h0, (ec == 0)});
  endtask

  task automatic apply(input logic rst, input logic en, input logic [1:0] mode,
                       input logic [W-1:0] d, input logic [N*W-1:0] ld);
    reset_i = rst;
    E_i     = en;
    mode_i  = mode;
    D_i     = d;
    load_i  = ld;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic rst, logic en, logic [1:0] mode, logic [W-1:0] d,
                              logic [N*W-1:0] ld, logic [N*W-1:0] et, logic [N-1:0] ev, int ec);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = mode; v.d = d; v.load = ld;
    v.exp_taps = et; v.exp_valid = ev; v.exp_count = ec;
    return v;
  endfunction

  // Behavioural model: stage array indexed 0..N-1, count is the popcount of the valid flags.
  logic [W-1:0] m_data [N];
  logic         m_valid[N];

  function automatic logic [N*W-1:0] m_taps();
    logic [N*W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = m_data[k];
    return r;
  endfunction

  function automatic logic [N-1:0] m_vbits();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = m_valid[k];
    return r;
  endfunction

  function automatic int m_count();
    int c;
    c = 0;
    for (int k = 0; k < N; k++) c += int'(m_valid[k]);
    return c;
  endfunction

  task automatic m_step(input logic rst, input logic en, input logic [1:0] mode,
                        input logic [W-1:0] d, input logic [N*W-1:0] ld);
    if (rst || (en && mode == 2'b11)) begin
      for (int k = 0; k < N; k++) begin m_data[k] = 8'h00; m_valid[k] = 1'b0; end
    end else if (en && mode == 2'b01) begin
      for (int k = N-1; k > 0; k--) begin m_data[k] = m_data[k-1]; m_valid[k] = m_valid[k-1]; end
      m_data[0]  = d;
      m_valid[0] = 1'b1;
    end else if (en && mode == 2'b10) begin
      for (int k = 0; k < N; k++) begin m_data[k] = ld[k*W +: W]; m_valid[k] = 1'b1; end
    end
  endtask

  initial begin
    reset_i = 1'b1; E_i = 1'b0; mode_i = 2'b00; D_i = '0; load_i = '0;

    // rst en mode d load | taps valid count
    vecs.push_back(mk(1, 0, 2'b00, 8'h00, 32'h0,        32'h00000000, 4'h0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 8'hA1, 32'h0,        32'h000000A1, 4'h1, 1));
    vecs.push_back(mk(0, 1, 2'b01, 8'hA2, 32'h0,        32'h0000A1A2, 4'h3, 2));
    vecs.push_back(mk(0, 1, 2'b01, 8'hA3, 32'h0,        32'h00A1A2A3, 4'h7, 3));
    vecs.push_back(mk(0, 1, 2'b01, 8'hA4, 32'h0,        32'hA1A2A3A4, 4'hF, 4));
    vecs.push_back(mk(0, 1, 2'b01, 8'hA5, 32'h0,        32'hA2A3A4A5, 4'hF, 4));
    vecs.push_back(mk(0, 1, 2'b10, 8'h00, 32'h44332211, 32'h44332211, 4'hF, 4));
    vecs.push_back(mk(0, 0, 2'b01, 8'hFF, 32'h0,        32'h44332211, 4'hF, 4));
    vecs.push_back(mk(0, 0, 2'b01, 8'hEE, 32'h0,        32'h44332211, 4'hF, 4));
    vecs.push_back(mk(0, 0, 2'b11, 8'hDD, 32'h0,        32'h44332211, 4'hF, 4));
    vecs.push_back(mk(0, 1, 2'b00, 8'hCC, 32'h12345678, 32'h44332211, 4'hF, 4));
    vecs.push_back(mk(0, 1, 2'b11, 8'h00, 32'h0,        32'h00000000, 4'h0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 8'h11, 32'h0,        32'h00000011, 4'h1, 1));
    vecs.push_back(mk(0, 1, 2'b01, 8'h22, 32'h0,        32'h00001122, 4'h3, 2));
    vecs.push_back(mk(0, 1, 2'b11, 8'h33, 32'h0,        32'h00000000, 4'h0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 8'h55, 32'h0,        32'h00000055, 4'h1, 1));
    vecs.push_back(mk(1, 1, 2'b10, 8'h00, 32'h12345678, 32'h00000000, 4'h0, 0));
    vecs.push_back(mk(0, 1, 2'b10, 8'h00, 32'hDEADBEEF, 32'hDEADBEEF, 4'hF, 4));
    vecs.push_back(mk(1, 0, 2'b01, 8'h77, 32'h0,        32'h00000000, 4'h0, 0));

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].load);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_taps, vecs[i].exp_valid, vecs[i].exp_count);
    end

`ifdef FPGA_DFFER_PIPE_PARITY_EN
    apply(1, 0, 2'b00, 8'h00, 32'h0);
    check("par.reset", {28'h0, par_o}, 32'h0);
    apply(0, 1, 2'b01, 8'h07, 32'h0);
    check("par.s07", {31'h0, par_o[0]}, 32'h1);
    apply(0, 1, 2'b01, 8'h03, 32'h0);
    check("par.s03", {30'h0, par_o[1:0]}, 32'h2);
`endif

    // Randomized run against the model, starting from reset.
    apply(1, 0, 2'b00, 8'h00, 32'h0);
    m_step(1, 0, 2'b00, 8'h00, 32'h0);
    for (int i = 0; i < 400; i++) begin
      logic           r_rst, r_en;
      logic [1:0]     r_mode;
      logic [W-1:0]   r_d;
      logic [N*W-1:0] r_ld;
      int             sel;
      r_rst = ($urandom_range(0, 31) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      sel   = $urandom_range(0, 15);
      r_mode = (sel < 9) ? 2'b01 : (sel < 11) ? 2'b00 : (sel < 13) ? 2'b10 : 2'b11;
      r_d   = W'($urandom);
      r_ld  = $urandom;
      apply(r_rst, r_en, r_mode, r_d, r_ld);
      m_step(r_rst, r_en, r_mode, r_d, r_ld);
      check_outputs($sformatf("rnd%0d", i), m_taps(), m_vbits(), m_count());
`ifdef FPGA_DFFER_PIPE_PARITY_EN
      begin
        logic [N-1:0] ep;
        for (int k = 0; k < N; k++) ep[k] = ^m_data[k];
        check($sformatf("rnd%0d.par", i), {28'h0, par_o}, {28'h0, ep});
      end
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_fpga_dffer_pipe
